// File: rtl/pu_mac_array.sv
// Three-stage multiply-accumulate array: CH unsigned products, a summing stage, and a
// saturating accumulator that emits one result per beat or one per in_last-closed packet.
module pu_mac_array #(
    parameter  int CH      = 4,
    parameter  int DW      = 5,
    parameter  int ACC_EXT = 4,
    localparam int PW      = 2 * DW,
    localparam int SW      = PW + $clog2(CH),
    localparam int OW      = SW + ACC_EXT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic             acc_mode,
    input  logic [CH*DW-1:0] x_flat,
    input  logic [CH*DW-1:0] w_flat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    out_data,
    output logic             out_ovf
);

    localparam int LEAVES = 1 << $clog2(CH);
    localparam int TW     = OW + 1;

    logic          stall;
    logic [PW-1:0] prod_c [LEAVES];

    logic          s1_valid, s1_last, s1_mode;
    logic [PW-1:0] s1_prod [LEAVES];

    logic          s2_valid, s2_last, s2_mode;
    logic [SW-1:0] s2_sum;
    logic [SW-1:0] tree_sum;

    logic [OW-1:0] acc;
    logic          sticky;
    logic [TW-1:0] total;
    logic          clamp;
    logic [OW-1:0] sat_val;
    logic          close_pkt;

    // A pending, unaccepted result freezes the whole pipeline.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    // Leaves beyond CH are tied to zero so the tree is always a full power of two.
    for (genvar g = 0; g < LEAVES; g++) begin : g_leaf
        if (g < CH) begin : g_mul
            assign prod_c[g] = PW'(x_flat[g*DW +: DW]) * PW'(w_flat[g*DW +: DW]);
        end else begin : g_pad
            assign prod_c[g] = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples the
    // previous stage's pre-edge value; blocking here would collapse the pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= 1'b0;
            // NOTE: the product bank is a handful of flops, not a RAM, so it is reset
            // with everything else to keep post-reset state fully defined.
            for (int i = 0; i < LEAVES; i++) s1_prod[i] <= '0;
        end else if (!stall) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            s1_mode  <= acc_mode;
            s1_prod  <= prod_c;
        end
    end

    // SW is wide enough for CH full-scale products, so this sum is exact.
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < LEAVES; i++) tree_sum = tree_sum + SW'(s1_prod[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_mode  <= 1'b0;
            s2_sum   <= '0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_mode  <= s1_mode;
            s2_sum   <= tree_sum;
        end
    end

    // One extra bit catches the carry out of acc + sum for saturation.
    always_comb begin
        total     = {1'b0, acc} + TW'(s2_sum);
        clamp     = total[OW];
        sat_val   = clamp ? '1 : total[OW-1:0];
        close_pkt = !s2_mode || s2_last;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            sticky    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (!stall) begin
            out_valid <= s2_valid && close_pkt;
            if (s2_valid) begin
                if (close_pkt) begin
                    out_data <= sat_val;
                    out_ovf  <= sticky || clamp;
                    acc      <= '0;
                    sticky   <= 1'b0;
                end else begin
                    acc    <= sat_val;
                    sticky <= sticky || clamp;
                end
            end
        end
    end

endmodule

// File: tb/tb_pu_mac_array.sv
// Randomized and directed bench for pu_mac_array: a packet-level reference model fills a
// scoreboard queue at acceptance, and a monitor pops it on every output handshake.
module tb_pu_mac_array;

    localparam int CH      = 4;
    localparam int DW      = 5;
    localparam int ACC_EXT = 4;
    localparam int OW      = 16;
    localparam int MAXV    = (1 << OW) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_last = 1'b0;
    logic             acc_mode = 1'b0;
    logic [CH*DW-1:0] x_flat = '0;
    logic [CH*DW-1:0] w_flat = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [OW-1:0]    out_data;
    logic             out_ovf;

    pu_mac_array #(.CH(CH), .DW(DW), .ACC_EXT(ACC_EXT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .acc_mode  (acc_mode),
        .x_flat    (x_flat),
        .w_flat    (w_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_acc = 0;
    bit   m_ovf = 1'b0;
    bit   rand_ready_en = 1'b0;

    localparam logic [CH*DW-1:0] ALL31 = '1;
    localparam logic [CH*DW-1:0] ONES  = {5'd1, 5'd1, 5'd1, 5'd1};
    localparam logic [CH*DW-1:0] PX    = {5'd4, 5'd3, 5'd2, 5'd1};
    localparam logic [CH*DW-1:0] PW_   = {5'd8, 5'd7, 5'd6, 5'd5};

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet-level reference: dot product, saturating running total, sticky clamp flag.
    function automatic void model_beat(input logic [CH*DW-1:0] x, input logic [CH*DW-1:0] w,
                                       input bit mode, input bit last);
        int   sum = 0;
        int   tot;
        exp_t e;
        for (int i = 0; i < CH; i++) sum += int'(x[i*DW +: DW]) * int'(w[i*DW +: DW]);
        tot = m_acc + sum;
        if (tot > MAXV) begin
            tot   = MAXV;
            m_ovf = 1'b1;
        end
        if (!mode || last) begin
            e.data = tot;
            e.ovf  = m_ovf;
            exp_q.push_back(e);
            m_acc = 0;
            m_ovf = 1'b0;
        end else begin
            m_acc = tot;
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
    task automatic send(input logic [CH*DW-1:0] x, input logic [CH*DW-1:0] w,
                        input bit mode, input bit last);
        int waited = 0;
        x_flat   = x;
        w_flat   = w;
        acc_mode = mode;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        check("accept_wait", in_ready, 1);
        @(posedge clk);
        #1;
        if (waited < 200) model_beat(x, w, mode, last);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_ovf"}, out_ovf, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    // Monitor: handshake rule, hold-stability under backpressure, and scoreboard pops.
    bit            stall_prev = 1'b0;
    logic [OW-1:0] held_data;
    logic          held_ovf;
    exp_t          mon_e;

    always @(negedge clk) begin
        if (rst) begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (stall_prev) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_data", out_data, held_data);
                check("stall_hold_ovf", out_ovf, held_ovf);
            end
            stall_prev = out_valid && !out_ready;
            held_data  = out_data;
            held_ovf   = out_ovf;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", out_data, mon_e.data);
                    check("out_ovf", out_ovf, mon_e.ovf);
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int t;
        logic [CH*DW-1:0] rx, rw;
        bit rm, rl;

        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single full-scale beat and its pass-through latency.
        send(ALL31, ALL31, 1'b0, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        check("latency_cycles", lat, 3);
        check("single_beat_3844", out_data, 3844);
        drain();

        // Three-beat accumulate packet: one output 210.
        for (int b = 0; b < 3; b++) send(PX, PW_, 1'b1, b == 2);
        drain();

        // Saturating packet, then a clean pass-through beat.
        for (int b = 0; b < 18; b++) send(ALL31, ALL31, 1'b1, b == 17);
        drain();
        send(ALL31, ALL31, 1'b0, 1'b0);
        drain();

        // Mode-0 beat terminates an open accumulation.
        send(PX, PW_, 1'b1, 1'b0);
        send(ONES, ONES, 1'b0, 1'b0);
        drain();

        // Backpressure for 5 cycles while streaming.
        fork
            begin
                for (int b = 0; b < 10; b++) send(20'($urandom), 20'($urandom), 1'b0, 1'b0);
            end
            begin
                t = 0;
                @(negedge clk);
                while (!out_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset mid-packet discards partial work.
        send(ALL31, ALL31, 1'b1, 1'b0);
        send(ALL31, ALL31, 1'b1, 1'b0);
        rst = 1'b0;
        exp_q.delete();
        m_acc = 0;
        m_ovf = 1'b0;
        #2;
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        check_reset_outputs("held_reset");
        rst = 1'b1;
        @(posedge clk);
        #1;
        send(ONES, ONES, 1'b0, 1'b0);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        check("post_reset_sum_4", out_data, 4);
        drain();

        // Randomized traffic with random backpressure.
        rand_ready_en = 1'b1;
        for (int b = 0; b < 300; b++) begin
            rx = 20'($urandom);
            rw = 20'($urandom);
            rm = $urandom_range(0, 1) == 1;
            rl = $urandom_range(0, 3) == 0;
            send(rx, rw, rm, rl);
        end
        send(ONES, ONES, 1'b0, 1'b0);
        rand_ready_en = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
